piso: RTL and testbench

- Parallel-in, serial-out shifter; the transmit-side counterpart of the trickle sipo.
- Accepts one width_p*depth_p-bit word over a ready/valid handshake.
- Emits the word as depth_p beats of width_p bits over a valid/yumi handshake.
- Used to stream systolic_array results bit-serially off-chip, or back into a sipo for loopback testing.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_if.sv | 36 +++
 rtl/piso.sv | 80 ++++++++
 tb/tb_piso.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shifter.
package piso_pkg;

  typedef enum logic [0:0] {EMPTY, SHIFT} piso_state_e;

  // A counter needs at least one bit even when a word is a single beat.
  function automatic int beat_cnt_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_if.sv
// Word-in / beat-out handshake bundle for piso.
// Handshakes: a word moves when valid_i & ready_o on a rising edge; a beat
// moves when valid_o & yumi_i on a rising edge. ready_o may depend
// combinationally on yumi_i, so valid_i must never depend on ready_o.
interface piso_if #(
  parameter int width_p = 1,
  parameter int depth_p = 8
);
  logic                         ready_o;
  logic                         valid_i;
  logic [width_p*depth_p-1:0]   data_i;
  logic                         valid_o;
  logic [width_p-1:0]           data_o;
  logic                         yumi_i;
  logic                         last_o;

  modport slave (
    output ready_o,
    input  valid_i,
    input  data_i,
    output valid_o,
    output data_o,
    input  yumi_i,
    output last_o
  );

  modport master (
    input  ready_o,
    output valid_i,
    output data_i,
    input  valid_o,
    output yumi_i,
    input  data_o,
    input  last_o
  );
endinterface

// File: rtl/piso.sv
// Parallel-in, serial-out shifter: one width_p*depth_p word in, depth_p
// beats of width_p bits out, with a gap-free reload on the final beat.
module piso
  import piso_pkg::*;
#(
  parameter int width_p     = 1,
  parameter int depth_p     = 8,
  parameter int lsb_first_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  piso_if.slave       bus,
  output piso_state_e state_o
);

  localparam int cnt_w  = beat_cnt_width(depth_p);
  localparam int word_w = width_p * depth_p;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(depth_p - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_r;
  logic [cnt_w-1:0]  cnt_r;
  logic [word_w-1:0] shift_r;
  logic [word_w-1:0] shift_next;

  logic in_shift;
  logic last;
  logic ready;
  logic accept;
  logic take;

  assign in_shift = (state_r == ST_SHIFT);
  assign last     = in_shift && (cnt_r == last_cnt);
  assign ready    = !in_shift || (last && bus.yumi_i);
  assign accept   = bus.valid_i && ready;
  // yumi_i outside SHIFT is a protocol violation and is simply ignored.
  assign take     = in_shift && bus.yumi_i;

  always_comb begin
    shift_next = '0;
    if (lsb_first_p != 0) shift_next = shift_r >> width_p;
    else                  shift_next = shift_r << width_p;
  end

  // Shifting on the final beat too leaves the register zero once empty,
  // so data_o reads 0 whenever valid_o is low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_EMPTY;
      cnt_r   <= '0;
      shift_r <= '0;
    end else if (accept) begin
      state_r <= ST_SHIFT;
      cnt_r   <= '0;
      shift_r <= bus.data_i;
    end else if (take) begin
      shift_r <= shift_next;
      if (last) begin
        state_r <= ST_EMPTY;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + cnt_w'(1);
      end
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (lsb_first_p != 0) bus.data_o = shift_r[width_p-1:0];
    else                  bus.data_o = shift_r[word_w-1 -: width_p];
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = in_shift;
  assign bus.last_o  = last;
  assign state_o     = piso_state_e'(state_r);

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: a vector table for the 1x8 serializer plus
// hand-written sequences for the 4x2 (both orders) and 4x1 configurations.
module tb_piso;
  import piso_pkg::*;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  always #5 clk_i = ~clk_i;

  piso_if #(.width_p(1), .depth_p(8)) bus_a ();
  piso_if #(.width_p(4), .depth_p(2)) bus_b ();
  piso_if #(.width_p(4), .depth_p(2)) bus_c ();
  piso_if #(.width_p(4), .depth_p(1)) bus_d ();

  piso_state_e state_a, state_b, state_c, state_d;

  piso #(.width_p(1), .depth_p(8), .lsb_first_p(1)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_a), .state_o(state_a));
  piso #(.width_p(4), .depth_p(2), .lsb_first_p(1)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_b), .state_o(state_b));
  piso #(.width_p(4), .depth_p(2), .lsb_first_p(0)) dut_c (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_c), .state_o(state_c));
  piso #(.width_p(4), .depth_p(1), .lsb_first_p(1)) dut_d (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_d), .state_o(state_d));

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       yumi;
    logic       exp_ready;
    logic       exp_valid;
    logic       exp_data;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d] got %0h want %0h", name, idx, got, exp);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] w, input int k);
    return w[k];
  endfunction

  task automatic add_vec(input logic rst, input logic v, input logic [7:0] d,
                         input logic y, input logic er, input logic ev,
                         input logic ed, input logic el);
    vec_t t;
    t.rst = rst; t.valid = v; t.data = d; t.yumi = y;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_last = el;
    vecs.push_back(t);
  endtask

  task automatic add_accept(input logic [7:0] w);
    add_vec(1'b0, 1'b1, w, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_idle();
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Beats lo..hi of w consumed with yumi_i=1; nv/nd are offered on beat 7.
  task automatic add_beats(input logic [7:0] w, input int lo, input int hi,
                           input logic nv, input logic [7:0] nd);
    for (int k = lo; k <= hi; k++) begin
      add_vec(1'b0, (k == 7) ? nv : 1'b0, nd, 1'b1,
              (k == 7), 1'b1, bit_of(w, k), (k == 7));
    end
  endtask

  // Drive the small DUTs, wait to the falling edge, return to post-edge.
  task automatic step_small(input logic v, input logic [7:0] d, input logic y,
                            input logic dv, input logic [3:0] dd, input logic dy);
    bus_b.valid_i = v; bus_b.data_i = d; bus_b.yumi_i = y;
    bus_c.valid_i = v; bus_c.data_i = d; bus_c.yumi_i = y;
    bus_d.valid_i = dv; bus_d.data_i = dd; bus_d.yumi_i = dy;
    @(negedge clk_i);
  endtask

  initial begin
    bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.yumi_i = 1'b0;
    bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.yumi_i = 1'b0;
    bus_c.valid_i = 1'b0; bus_c.data_i = '0; bus_c.yumi_i = 1'b0;
    bus_d.valid_i = 1'b0; bus_d.data_i = '0; bus_d.yumi_i = 1'b0;

    // Single word, then idle.
    add_accept(8'hA5);
    add_beats(8'hA5, 0, 7, 1'b0, 8'h00);
    add_idle();
    // Back-to-back with the next word offered on the final yumi.
    add_accept(8'hA5);
    add_beats(8'hA5, 0, 7, 1'b1, 8'h3C);
    add_beats(8'h3C, 0, 7, 1'b0, 8'h00);
    add_idle();
    // Backpressure: beat 2 held for three cycles.
    add_accept(8'hF0);
    add_beats(8'hF0, 0, 1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++)
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_beats(8'hF0, 2, 7, 1'b0, 8'h00);
    add_idle();
    // Busy reject: 8'hFF offered mid-word is never sampled.
    add_accept(8'h00);
    add_beats(8'h00, 0, 2, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++)
      add_vec(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_beats(8'h00, 3, 7, 1'b0, 8'h00);
    add_idle();
    // Reset while beat 4 of 8'hA5 is presented, then a fresh word.
    add_accept(8'hA5);
    add_beats(8'hA5, 0, 3, 1'b0, 8'h00);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, bit_of(8'hA5, 4), 1'b0);
    add_accept(8'h01);
    add_beats(8'h01, 0, 7, 1'b0, 8'h00);
    add_idle();

    // Reset state of every instance.
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    check("rst_ready_a", 0, 8'(bus_a.ready_o), 8'h1);
    check("rst_valid_a", 0, 8'(bus_a.valid_o), 8'h0);
    check("rst_data_a",  0, 8'(bus_a.data_o),  8'h0);
    check("rst_last_a",  0, 8'(bus_a.last_o),  8'h0);
    check("rst_state_a", 0, 8'(state_a), 8'(EMPTY));
    check("rst_valid_b", 0, 8'(bus_b.valid_o), 8'h0);
    check("rst_data_c",  0, 8'(bus_c.data_o),  8'h0);
    check("rst_ready_d", 0, 8'(bus_d.ready_o), 8'h1);
    @(posedge clk_i); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset_i       = vecs[i].rst;
      bus_a.valid_i = vecs[i].valid;
      bus_a.data_i  = vecs[i].data;
      bus_a.yumi_i  = vecs[i].yumi;
      @(negedge clk_i);
      n_vec++;
      check("ready", i, 8'(bus_a.ready_o), 8'(vecs[i].exp_ready));
      check("valid", i, 8'(bus_a.valid_o), 8'(vecs[i].exp_valid));
      check("data",  i, 8'(bus_a.data_o),  8'(vecs[i].exp_data));
      check("last",  i, 8'(bus_a.last_o),  8'(vecs[i].exp_last));
      check("state", i, 8'(state_a), vecs[i].exp_valid ? 8'(SHIFT) : 8'(EMPTY));
      @(posedge clk_i); #1;
    end
    reset_i = 1'b0;
    bus_a.valid_i = 1'b0; bus_a.yumi_i = 1'b0;

    // 4x2 in both orders with 8'h5A; 4x1 streams 3 then 9 back-to-back.
    step_small(1'b1, 8'h5A, 1'b0, 1'b1, 4'h3, 1'b0);
    n_vec++;
    check("b_ready0", 0, 8'(bus_b.ready_o), 8'h1);
    check("c_valid0", 0, 8'(bus_c.valid_o), 8'h0);
    check("d_ready0", 0, 8'(bus_d.ready_o), 8'h1);
    @(posedge clk_i); #1;

    step_small(1'b0, 8'h00, 1'b1, 1'b1, 4'h9, 1'b1);
    n_vec++;
    check("b_beat0", 1, 8'(bus_b.data_o), 8'hA);
    check("b_last0", 1, 8'(bus_b.last_o), 8'h0);
    check("c_beat0", 1, 8'(bus_c.data_o), 8'h5);
    check("c_last0", 1, 8'(bus_c.last_o), 8'h0);
    check("c_ready0", 1, 8'(bus_c.ready_o), 8'h0);
    check("d_beat0", 1, 8'(bus_d.data_o), 8'h3);
    check("d_last0", 1, 8'(bus_d.last_o), 8'h1);
    check("d_ready1", 1, 8'(bus_d.ready_o), 8'h1);
    @(posedge clk_i); #1;

    step_small(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1);
    n_vec++;
    check("b_beat1", 2, 8'(bus_b.data_o), 8'h5);
    check("b_last1", 2, 8'(bus_b.last_o), 8'h1);
    check("c_beat1", 2, 8'(bus_c.data_o), 8'hA);
    check("c_last1", 2, 8'(bus_c.last_o), 8'h1);
    check("b_ready1", 2, 8'(bus_b.ready_o), 8'h1);
    check("d_valid1", 2, 8'(bus_d.valid_o), 8'h1);
    check("d_beat1", 2, 8'(bus_d.data_o), 8'h9);
    @(posedge clk_i); #1;

    step_small(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    n_vec++;
    check("b_valid_end", 3, 8'(bus_b.valid_o), 8'h0);
    check("c_data_end",  3, 8'(bus_c.data_o),  8'h0);
    check("d_valid_end", 3, 8'(bus_d.valid_o), 8'h0);
    check("d_ready_end", 3, 8'(bus_d.ready_o), 8'h1);
    @(posedge clk_i); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
